// File: rtl/hazard_scoreboard_if.sv
// Pipeline-to-hazard-unit bundle: stage addresses/controls in, forwarding and stall/flush controls out.
interface hazard_scoreboard_if #(
  parameter int unsigned AW = 4
);
  logic [AW-1:0] RA1D, RA2D, WA3D;
  logic          RegWriteD, MultiCycleD;
  logic [AW-1:0] RA1E, RA2E, WA3E;
  logic          RegWriteE, MemtoRegE, MultiCycleE;
  logic [AW-1:0] WA3M, WA3W;
  logic          RegWriteM, RegWriteW;
  logic          PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, FlushD, FlushE;
  logic          McBusy, McDone;
  logic [AW-1:0] McWA;

  modport master (
    output RA1D, RA2D, WA3D, RegWriteD, MultiCycleD,
    output RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, MultiCycleE,
    output WA3M, WA3W, RegWriteM, RegWriteW,
    output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    input  McBusy, McDone, McWA
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteD, MultiCycleD,
    input  RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, MultiCycleE,
    input  WA3M, WA3W, RegWriteM, RegWriteW,
    input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    output McBusy, McDone, McWA
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit with a single-entry scoreboard for one in-flight multi-cycle op.
// Define HAZARD_FWD_EN to enable operand forwarding; otherwise dependent ops stall until the register file holds the value.
module hazard_scoreboard #(
  parameter int unsigned AW     = 4,
  parameter int unsigned MC_LAT = 4
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave bus
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_WB} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] mc_wa, mc_wa_nxt;
  logic          mc_done;
  logic          mc_busy;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      mc_wa <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      mc_wa <= mc_wa_nxt;
    end
  end

  // Next state; the result may only retire when the write port is free
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mc_wa_nxt = mc_wa;
    mc_done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.MultiCycleE) begin
          mc_wa_nxt = bus.WA3E;
          cnt_nxt   = CW'(MC_LAT - 1);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else if (!bus.RegWriteW) begin
          mc_done   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_WB;
        end
      end
      WAIT_WB: begin
        if (!bus.RegWriteW) begin
          mc_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mc_busy = (state != IDLE);

  logic ldr_stall, scb_stall, struct_stall, dep_stall, scb_hit;
  logic stall_d;

  assign ldr_stall    = bus.MemtoRegE & bus.RegWriteE &
                        ((bus.RA1D == bus.WA3E) | (bus.RA2D == bus.WA3E));
  assign scb_hit      = (bus.RA1D == mc_wa) | (bus.RA2D == mc_wa) |
                        (bus.RegWriteD & (bus.WA3D == mc_wa));
  assign struct_stall = bus.MultiCycleD & (mc_busy | bus.MultiCycleE);

`ifdef HAZARD_FWD_EN
  assign scb_stall = mc_busy & ~mc_done & scb_hit;
  assign dep_stall = 1'b0;

  // Forward select: Memory beats Writeback beats the retiring multi-cycle result
  always_comb begin
    bus.ForwardAE = 2'b00;
    if (bus.RegWriteM && (bus.RA1E == bus.WA3M))      bus.ForwardAE = 2'b10;
    else if (bus.RegWriteW && (bus.RA1E == bus.WA3W)) bus.ForwardAE = 2'b01;
    else if (mc_done && (bus.RA1E == mc_wa))          bus.ForwardAE = 2'b11;
  end

  always_comb begin
    bus.ForwardBE = 2'b00;
    if (bus.RegWriteM && (bus.RA2E == bus.WA3M))      bus.ForwardBE = 2'b10;
    else if (bus.RegWriteW && (bus.RA2E == bus.WA3W)) bus.ForwardBE = 2'b01;
    else if (mc_done && (bus.RA2E == mc_wa))          bus.ForwardBE = 2'b11;
  end
`else
  // Without forwarding the consumer waits until the result is in the register file
  assign scb_stall = mc_busy & scb_hit;
  assign dep_stall = (bus.RegWriteE & ((bus.RA1D == bus.WA3E) | (bus.RA2D == bus.WA3E))) |
                     (bus.RegWriteM & ((bus.RA1D == bus.WA3M) | (bus.RA2D == bus.WA3M)));
  assign bus.ForwardAE = 2'b00;
  assign bus.ForwardBE = 2'b00;
`endif

  assign stall_d    = ldr_stall | scb_stall | struct_stall | dep_stall;
  assign bus.StallD = stall_d;
  assign bus.StallF = stall_d | bus.PCSrcD | bus.PCSrcE | bus.PCSrcM;
  assign bus.FlushD = bus.PCSrcD | bus.PCSrcE | bus.PCSrcM | bus.PCSrcW | bus.BranchTakenE;
  assign bus.FlushE = stall_d | bus.BranchTakenE;
  assign bus.McBusy = mc_busy;
  assign bus.McDone = mc_done;
  assign bus.McWA   = mc_wa;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter AW, default 4, register-address width (2**AW architectural registers).
REQ-002 Parameter MC_LAT, default 4, multi-cycle unit latency in cycles, legal range 2..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 RA1D, RA2D, WA3D  input  AW  Decode source addresses and destination address.
REQ-006 RegWriteD, MultiCycleD  input  1  Decode instruction writes a register / is a multi-cycle op.
REQ-007 RA1E, RA2E, WA3E  input  AW  Execute source and destination addresses.
REQ-008 RegWriteE, MemtoRegE, MultiCycleE  input  1  Execute writes a register / is a load / is a multi-cycle op.
REQ-009 WA3M, WA3W  input  AW  Memory and Writeback destination addresses.
REQ-010 RegWriteM, RegWriteW  input  1  Memory / Writeback stage writes the register file.
REQ-011 PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE  input  1  PC-write pending per stage; branch taken in Execute.
REQ-012 ForwardAE, ForwardBE  output  2  00 register file, 01 Writeback, 10 Memory, 11 multi-cycle result.
REQ-013 StallF, StallD, FlushD, FlushE  output  1  pipeline stall/flush controls.
REQ-014 McBusy, McDone  output  1  multi-cycle unit occupied; result is on the register-file write port this cycle.
REQ-015 McWA  output  AW  destination register of the pending multi-cycle op.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY and WAIT_WB, plus a down-counter cnt of 4 bits.
REQ-017 Accept SHALL be MultiCycleE while in IDLE; on accept: McWA<=WA3E, cnt<=MC_LAT-1, state<=BUSY.
REQ-018 In BUSY with cnt!=0, cnt SHALL decrement each cycle.
REQ-019 In BUSY with cnt==0: if RegWriteW=0 then McDone=1 and next state IDLE; otherwise McDone=0 and next state WAIT_WB.
REQ-020 In WAIT_WB: if RegWriteW=0 then McDone=1 and next state IDLE; otherwise remain in WAIT_WB.
REQ-021 McDone SHALL be 1 only in the cycles defined by REQ-019/020; the earliest McDone is MC_LAT cycles after the accept cycle.
REQ-022 McBusy SHALL be (state!=IDLE).
REQ-023 ldrStall = MemtoRegE & RegWriteE & (RA1D==WA3E | RA2D==WA3E).
REQ-024 scbStall = McBusy & ~McDone & (RA1D==McWA | RA2D==McWA | (RegWriteD & WA3D==McWA)); this covers RAW and WAW hazards on the pending register.
REQ-025 structStall = MultiCycleD & (McBusy | MultiCycleE), since only one multi-cycle op is in flight at a time.
REQ-026 StallD SHALL be ldrStall | scbStall | structStall.
REQ-027 StallF SHALL be StallD | PCSrcD | PCSrcE | PCSrcM.
REQ-028 FlushD SHALL be PCSrcD | PCSrcE | PCSrcM | PCSrcW | BranchTakenE.
REQ-029 FlushE SHALL be StallD | BranchTakenE.
REQ-030 ForwardAE priority SHALL be: RegWriteM & RA1E==WA3M gives 10; else RegWriteW & RA1E==WA3W gives 01; else McDone & RA1E==McWA gives 11; else 00.
REQ-031 ForwardBE SHALL use the same priority as REQ-030, applied to RA2E.
REQ-032 All outputs other than the FSM-derived outputs SHALL be combinational, with zero-cycle latency from the inputs.

Reset
REQ-033 When reset=1 at a clock edge: state<=IDLE, cnt<=0, McWA<=0.
REQ-034 After reset: McBusy=0, McDone=0; scbStall and the McBusy term of structStall are 0.
REQ-035 Reset asserted mid-operation SHALL abandon the pending op with no McDone pulse.

Configuration
REQ-036 With HAZARD_FWD_EN defined, forwarding SHALL operate as in REQ-030/031.
REQ-037 With HAZARD_FWD_EN undefined, ForwardAE=ForwardBE=00 constantly.
REQ-038 With HAZARD_FWD_EN undefined, StallD SHALL additionally assert when RA1D or RA2D matches WA3E with RegWriteE, or WA3M with RegWriteM.
REQ-039 With HAZARD_FWD_EN undefined, the multi-cycle result SHALL be consumed only via the register file, with scbStall held through the McDone cycle.

Verification (MC_LAT=4, HAZARD_FWD_EN defined unless noted)
REQ-040 Load-use: MemtoRegE=1, RegWriteE=1, WA3E=3, RA1D=3 -> StallF=StallD=FlushE=1 for that cycle only.
REQ-041 Multi-cycle op: MultiCycleE=1, WA3E=5 at cycle 0, RegWriteW=0 -> McBusy=1 in cycles 1-4, McDone=1 in cycle 4, McWA=5; D reading R5 stalls in cycles 1-3; RA2E=5 in cycle 4 -> ForwardBE=11.
REQ-042 Writeback collision: as REQ-041 but RegWriteW=1 in cycles 4-5 -> WAIT_WB, McDone=1 in cycle 6, scbStall held through cycle 5.
REQ-043 Structural hazard and reset: MultiCycleD=1 while McBusy=1 -> StallD=1 until McBusy clears; reset=1 in cycle 2 -> McBusy=0 and no McDone pulse.
REQ-044 Branch plus priority: BranchTakenE=1 -> FlushD=FlushE=1; RA1E=WA3M=WA3W=7 with both RegWrite=1 -> ForwardAE=10.
REQ-045 With HAZARD_FWD_EN undefined: RA1D=WA3M=2, RegWriteM=1 -> StallD=1, ForwardAE=00.
